// File: rtl/pong_match_controller.sv
// Pong match sequencer: game state, ball motion, paddle/wall collision,
// scoring, serve timing and winner. Every update is qualified by frame_tick.
module pong_match_controller #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_HALF = 40,
  parameter int LEFT_PAD_X  = 20,
  parameter int RIGHT_PAD_X = 620,
  parameter int BALL_SPEED  = 1,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start_button,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       paddle_enable,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic [1:0] game_state,
  output logic       winner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [9:0]    CX      = 10'(SCREEN_W / 2);
  localparam logic [9:0]    CY      = 10'(SCREEN_H / 2);
  localparam logic [9:0]    SPD     = 10'(BALL_SPEED);
  localparam logic [9:0]    Y_MAX   = 10'(SCREEN_H - 1 - BALL_SPEED);
  localparam logic [9:0]    X_MAX   = 10'(SCREEN_W - 1 - BALL_SPEED);
  localparam logic [9:0]    L_FACE  = 10'(LEFT_PAD_X);
  localparam logic [9:0]    L_REACH = 10'(LEFT_PAD_X + BALL_SPEED);
  localparam logic [9:0]    R_FACE  = 10'(RIGHT_PAD_X);
  localparam logic [9:0]    R_REACH = 10'(RIGHT_PAD_X - BALL_SPEED);
  localparam logic [9:0]    PHALF   = 10'(PADDLE_HALF);
  localparam logic [3:0]    WIN     = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SD_LAST = CW'(SERVE_DELAY - 1);

  // Unsigned distance, larger minus smaller so it never wraps.
  function automatic logic [9:0] adiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t        state_q, state_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  logic          dx_q, dx_d;   // 1 = moving right
  logic          dy_q, dy_d;   // 1 = moving down
  logic [3:0]    ls_q, ls_d, rs_q, rs_d;
  logic          win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sp_q, sp_d;   // start_button seen on the previous frame

  logic       press;
  logic       l_hit, r_hit, l_miss, r_miss;
  logic [3:0] ls_inc, rs_inc;

  assign press  = sp_q && !start_button;
  assign l_hit  = !dx_q && (bx_q <= L_REACH) && (bx_q > L_FACE) &&
                  (adiff(by_q, left_paddle_y) <= PHALF);
  assign r_hit  = dx_q && (bx_q >= R_REACH) && (bx_q < R_FACE) &&
                  (adiff(by_q, right_paddle_y) <= PHALF);
  assign l_miss = !dx_q && (bx_q <= SPD);
  assign r_miss = dx_q && (bx_q >= X_MAX);
  assign ls_inc = ls_q + 4'd1;
  assign rs_inc = rs_q + 4'd1;

  // State register bank; everything returns to the idle/centred setup on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bx_q    <= CX;
      by_q    <= CY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      ls_q    <= 4'd0;
      rs_q    <= 4'd0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
      sp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      ls_q    <= ls_d;
      rs_q    <= rs_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
    end
  end

  // Per-frame match sequencing: serve countdown, motion, collisions, scoring.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    ls_d    = ls_q;
    rs_d    = rs_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    if (frame_tick) begin
      sp_d = start_button;
      case (state_q)
        S_IDLE, S_OVER: begin
          bx_d = CX;
          by_d = CY;
          if (press) begin
            ls_d    = 4'd0;
            rs_d    = 4'd0;
            cnt_d   = '0;
            dx_d    = 1'b1;
            dy_d    = ~dy_q;
            state_d = S_SERVE;
          end
        end
        S_SERVE: begin
          bx_d = CX;
          by_d = CY;
          if (cnt_q == SD_LAST) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PLAY: begin
          // Vertical: wall reflection holds position for the tick.
          if (!dy_q && by_q <= SPD)        dy_d = 1'b1;
          else if (dy_q && by_q >= Y_MAX)  dy_d = 1'b0;
          else                             by_d = dy_q ? by_q + SPD : by_q - SPD;
          // Horizontal: paddle reflection, miss, or free motion.
          if (l_hit)       dx_d = 1'b1;
          else if (r_hit)  dx_d = 1'b0;
          else if (!l_miss && !r_miss)
            bx_d = dx_q ? bx_q + SPD : bx_q - SPD;
          // A point recentres the ball; loser receives the next serve.
          if (l_miss || r_miss) begin
            bx_d  = CX;
            by_d  = CY;
            cnt_d = '0;
            if (l_miss) rs_d = rs_inc;
            else        ls_d = ls_inc;
            if ((l_miss && rs_inc == WIN) || (r_miss && ls_inc == WIN)) begin
              win_d   = l_miss;
              state_d = S_OVER;
            end else begin
              dx_d    = r_miss;
              dy_d    = ~dy_q;
              state_d = S_SERVE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ball_x        = bx_q;
  assign ball_y        = by_q;
  assign left_score    = ls_q;
  assign right_score   = rs_q;
  assign game_state    = state_q;
  assign winner        = win_q;
  assign paddle_enable = (state_q == S_SERVE) || (state_q == S_PLAY);

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: a table of frame-tick steps with
// hand-derived ball positions and scores, plus frame-gating and async reset.
module tb_pong_match_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_button = 1'b1;
  logic [9:0] left_paddle_y = 10'd240;
  logic [9:0] right_paddle_y = 10'd240;
  logic [9:0] ball_x, ball_y;
  logic       paddle_enable, winner;
  logic [3:0] left_score, right_score;
  logic [1:0] game_state;

  int nchk = 0;
  int nerr = 0;

  pong_match_controller #(
    .SERVE_DELAY(4),
    .WIN_SCORE  (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .start_button  (start_button),
    .left_paddle_y (left_paddle_y),
    .right_paddle_y(right_paddle_y),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .paddle_enable (paddle_enable),
    .left_score    (left_score),
    .right_score   (right_score),
    .game_state    (game_state),
    .winner        (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       btn;
    logic [9:0] lp, rp;
    logic [1:0] st;
    logic [9:0] x, y;
    logic [3:0] ls, rs;
    logic       pe, win;
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic btn, input int lp, input int rp,
                     input int st, input int x, input int y, input int ls,
                     input int rs, input logic pe, input logic win, input string name);
    vec_t v;
    v.n = n; v.btn = btn; v.lp = 10'(lp); v.rp = 10'(rp); v.st = 2'(st);
    v.x = 10'(x); v.y = 10'(y); v.ls = 4'(ls); v.rs = 4'(rs);
    v.pe = pe; v.win = win; v.name = name;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int st, input int x, input int y,
                         input int ls, input int rs, input logic pe, input logic win);
    chk({nm, ".state"}, 32'(game_state),    32'(st));
    chk({nm, ".x"},     32'(ball_x),        32'(x));
    chk({nm, ".y"},     32'(ball_y),        32'(y));
    chk({nm, ".lscore"},32'(left_score),    32'(ls));
    chk({nm, ".rscore"},32'(right_score),   32'(rs));
    chk({nm, ".pen"},   32'(paddle_enable), 32'(pe));
    chk({nm, ".winner"},32'(winner),        32'(win));
  endtask

  // One frame pulse; returns at the falling edge after it was consumed.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  initial begin
    //  n   btn lp   rp   st  x    y    ls rs pe win name
    add(5,   1, 240, 240, 0, 320, 240, 0, 0, 0, 0, "idle_hold");
    add(1,   0, 240, 240, 1, 320, 240, 0, 0, 1, 0, "press");
    add(3,   0, 240, 240, 1, 320, 240, 0, 0, 1, 0, "serve_wait");
    add(1,   0, 240, 240, 2, 320, 240, 0, 0, 1, 0, "play_enter");
    add(1,   0, 240, 240, 2, 321, 239, 0, 0, 1, 0, "play_step");
    add(238, 0, 240, 240, 2, 559,   1, 0, 0, 1, 0, "top_y1");
    add(1,   0, 240, 240, 2, 560,   1, 0, 0, 1, 0, "wall_hold");
    add(1,   0, 240, 240, 2, 561,   2, 0, 0, 1, 0, "wall_down");
    add(58,  0, 240, 100, 2, 619,  60, 0, 0, 1, 0, "right_face");
    add(1,   0, 240, 100, 2, 619,  61, 0, 0, 1, 0, "right_hit40");
    add(1,   0, 240, 100, 2, 618,  62, 0, 0, 1, 0, "right_recoil");
    add(597, 0, 339, 100, 2,  21, 298, 0, 0, 1, 0, "left_face");
    add(1,   0, 339, 100, 2,  20, 297, 0, 0, 1, 0, "left_miss41");
    add(19,  0, 339, 100, 2,   1, 278, 0, 0, 1, 0, "left_edge");
    add(1,   0, 339, 100, 1, 320, 240, 0, 1, 1, 0, "right_point");
    add(4,   0, 339, 100, 2, 320, 240, 0, 1, 1, 0, "serve2_play");
    add(1,   0, 339, 100, 2, 319, 241, 0, 1, 1, 0, "serve2_dir");
    add(298, 0, 378, 100, 2,  21, 418, 0, 1, 1, 0, "left_face2");
    add(1,   0, 378, 100, 2,  21, 417, 0, 1, 1, 0, "left_hit40");
    add(1,   0, 378, 100, 2,  22, 416, 0, 1, 1, 0, "left_recoil");
    add(597, 0, 378, 223, 2, 619, 182, 0, 1, 1, 0, "right_face2");
    add(1,   0, 378, 223, 2, 620, 183, 0, 1, 1, 0, "right_miss41");
    add(18,  0, 378, 223, 2, 638, 201, 0, 1, 1, 0, "right_edge");
    add(1,   0, 378, 223, 1, 320, 240, 1, 1, 1, 0, "left_point");
    add(4,   0, 240, 500, 2, 320, 240, 1, 1, 1, 0, "serve3_play");
    add(299, 0, 240, 500, 2, 619,  60, 1, 1, 1, 0, "r3_face");
    add(19,  0, 240, 500, 2, 638,  79, 1, 1, 1, 0, "r3_edge");
    add(1,   0, 240, 500, 3, 320, 240, 2, 1, 0, 0, "game_over");
    add(3,   0, 240, 500, 3, 320, 240, 2, 1, 0, 0, "held_no_restart");
    add(1,   1, 240, 500, 3, 320, 240, 2, 1, 0, 0, "release");
    add(1,   0, 240, 500, 1, 320, 240, 0, 0, 1, 0, "restart");
    add(4,   0, 240, 500, 2, 320, 240, 0, 0, 1, 0, "g2_play");
    add(318, 0, 240, 500, 2, 638,  79, 0, 0, 1, 0, "g2_edge");
    add(1,   0, 240, 500, 1, 320, 240, 1, 0, 1, 0, "g2_point");
    add(4,   0, 240, 500, 2, 320, 240, 1, 0, 1, 0, "g2_play2");
    add(3,   0, 240, 500, 2, 323, 237, 1, 0, 1, 0, "g2_mid");

    // Reset held while frames keep arriving.
    tick(3);
    chk_all("reset", 0, 320, 240, 0, 0, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      start_button   = vq[i].btn;
      left_paddle_y  = vq[i].lp;
      right_paddle_y = vq[i].rp;
      tick(vq[i].n);
      chk_all(vq[i].name, vq[i].st, vq[i].x, vq[i].y, vq[i].ls, vq[i].rs,
              vq[i].pe, vq[i].win);
    end

    // No frame pulse: nothing may move.
    repeat (10) @(negedge clk);
    chk_all("no_tick", 2, 323, 237, 1, 0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges, checked before the next edge.
    #2 reset_n = 1'b0;
    #1 chk_all("async_reset", 0, 320, 240, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
